result_converter_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational CORDIC result converter.
- Applies quadrant correction (flips from angle_normalizer) to fixed-point sin/cos from cordic.
- Converts both channels to IEEE-754 single precision with correct rounding.
- Uses a valid/ready handshake so it can sit between cordic and the output/bus interface with back-pressure.

---
 rtl/result_converter_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_result_converter_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_converter_pipe.sv
// result_converter_pipe: three-stage quadrant fold + fixed-point to IEEE-754
// single converter for the CORDIC sin/cos results, with valid/ready flow control.
//   S1: quadrant fold from the flips code, split into sign and magnitude.
//   S2: leading-one detect and normalise the magnitude to the MSB.
//   S3: round (or truncate) and pack into sign/exponent/mantissa.
// Build option: define RESULT_CONVERTER_PIPE_RNE_EN for round-to-nearest-even;
// without it the mantissa is truncated.
module result_converter_pipe #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       flips,
    input  logic [WIDTH-1:0] sin_in,
    input  logic [WIDTH-1:0] cos_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      sin_out,
    output logic [31:0]      cos_out,
    output logic             bad_flips
);
    localparam int PW = $clog2(WIDTH);
    localparam int EW = WIDTH + 24;

    // One extra bit so that negating the most negative input stays exact.
    typedef logic signed [WIDTH:0] wide_t;

    typedef struct packed {
        logic             sign;
        logic [WIDTH-1:0] mag;
    } s1_ch_t;

    typedef struct packed {
        logic             sign;
        logic             zero;
        logic [PW-1:0]    pos;
        logic [WIDTH-1:0] mag;
    } s2_ch_t;

    function automatic s1_ch_t to_sign_mag(input wide_t v);
        s1_ch_t r;
        r.sign = v[WIDTH];
        r.mag  = WIDTH'(v[WIDTH] ? -v : v);
        return r;
    endfunction

    // Leading-one position and shift so that the leading one lands on the MSB.
    function automatic s2_ch_t normalize(input s1_ch_t c);
        s2_ch_t        r;
        logic [PW-1:0] pos;
        pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (c.mag[i]) pos = PW'(i);
        end
        r.sign = c.sign;
        r.zero = (c.mag == '0);
        r.pos  = pos;
        r.mag  = c.mag << (PW'(WIDTH - 1) - pos);
        return r;
    endfunction

`ifdef RESULT_CONVERTER_PIPE_RNE_EN
    // Selects every bit of the padded word that lies below the guard bit.
    localparam logic [EW-1:0] STICKY_MASK = (EW'(1) << (WIDTH - 1)) - EW'(1);
`endif

    // Pack a normalised channel; zero padding covers inputs narrower than 24 bits.
    function automatic logic [31:0] pack(input s2_ch_t c);
        logic [EW-1:0] ext;
        logic [22:0]   mant;
        logic [7:0]    bexp;
`ifdef RESULT_CONVERTER_PIPE_RNE_EN
        logic          guard;
        logic          sticky;
`endif
        ext  = {c.mag, 24'd0};
        mant = 23'(ext >> WIDTH);
        bexp = 8'(int'(c.pos) - FRAC + 127);
`ifdef RESULT_CONVERTER_PIPE_RNE_EN
        guard  = ext[WIDTH-1];
        sticky = |(ext & STICKY_MASK);
        if (guard && (sticky || mant[0])) begin
            if (&mant) begin
                mant = '0;
                bexp = bexp + 8'd1;
            end else begin
                mant = mant + 23'd1;
            end
        end
`endif
        return c.zero ? 32'h0000_0000 : {c.sign, bexp, mant};
    endfunction

    logic   s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    logic   s1_bad_q, s1_bad_d, s2_bad_q, s2_bad_d, bad_flips_q, bad_flips_d;
    s1_ch_t s1_sin_q, s1_sin_d, s1_cos_q, s1_cos_d;
    s2_ch_t s2_sin_q, s2_sin_d, s2_cos_q, s2_cos_d;
    logic [31:0] sin_out_q, sin_out_d, cos_out_q, cos_out_d;
    logic   s2_load, s3_load;
    wide_t  s_w, c_w, c_abs, sin_f, cos_f;
    logic   fold_bad;

    // Combinational ready chain: a stage loads when it is empty or its contents move on.
    always_comb begin
        s3_load  = !s3_valid_q || out_ready;
        s2_load  = !s2_valid_q || s3_load;
        in_ready = !s1_valid_q || s2_load;
    end

    // S1: quadrant fold of the incoming sample.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        s_w      = {sin_in[WIDTH-1], sin_in};
        c_w      = {cos_in[WIDTH-1], cos_in};
        c_abs    = c_w[WIDTH] ? -c_w : c_w;
        sin_f    = s_w;
        cos_f    = c_abs;
        fold_bad = 1'b0;
        case (flips)
            3'b000: ;
            3'b001: begin sin_f = -c_abs; cos_f = s_w;    end
            3'b111: begin sin_f = c_abs;  cos_f = -s_w;   end
            3'b010,
            3'b110: begin sin_f = -s_w;   cos_f = -c_abs; end
            default: fold_bad = 1'b1;
        endcase

        s1_valid_d = s1_valid_q;
        s1_bad_d   = s1_bad_q;
        s1_sin_d   = s1_sin_q;
        s1_cos_d   = s1_cos_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_bad_d = fold_bad;
                s1_sin_d = to_sign_mag(sin_f);
                s1_cos_d = to_sign_mag(cos_f);
            end
        end
    end

    // S2: normalisation of both channels.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_bad_d   = s2_bad_q;
        s2_sin_d   = s2_sin_q;
        s2_cos_d   = s2_cos_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_bad_d = s1_bad_q;
                s2_sin_d = normalize(s1_sin_q);
                s2_cos_d = normalize(s1_cos_q);
            end
        end
    end

    // S3: round and pack; contents hold while the consumer stalls.
    always_comb begin
        s3_valid_d  = s3_valid_q;
        bad_flips_d = bad_flips_q;
        sin_out_d   = sin_out_q;
        cos_out_d   = cos_out_q;
        if (s3_load) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                bad_flips_d = s2_bad_q;
                sin_out_d   = pack(s2_sin_q);
                cos_out_d   = pack(s2_cos_q);
            end
        end
    end

    // Pipeline registers; reset drops every in-flight sample at once.
    // NOTE: state is updated with non-blocking assignments so all stages see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            s1_bad_q    <= 1'b0;
            s2_bad_q    <= 1'b0;
            bad_flips_q <= 1'b0;
            s1_sin_q    <= '0;
            s1_cos_q    <= '0;
            s2_sin_q    <= '0;
            s2_cos_q    <= '0;
            sin_out_q   <= '0;
            cos_out_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s3_valid_q  <= s3_valid_d;
            s1_bad_q    <= s1_bad_d;
            s2_bad_q    <= s2_bad_d;
            bad_flips_q <= bad_flips_d;
            s1_sin_q    <= s1_sin_d;
            s1_cos_q    <= s1_cos_d;
            s2_sin_q    <= s2_sin_d;
            s2_cos_q    <= s2_cos_d;
            sin_out_q   <= sin_out_d;
            cos_out_q   <= cos_out_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign sin_out   = sin_out_q;
    assign cos_out   = cos_out_q;
    assign bad_flips = bad_flips_q;

endmodule

// File: tb/tb_result_converter_pipe.sv
// tb_result_converter_pipe: directed-vector bench for result_converter_pipe
// (WIDTH=32, FRAC=31). Inputs change on the falling edge; outputs are read on
// the falling edge or shortly after it.
module tb_result_converter_pipe;
    localparam int WIDTH = 32;
    localparam int FRAC  = 31;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       flips;
    logic [WIDTH-1:0] sin_in;
    logic [WIDTH-1:0] cos_in;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      sin_out;
    logic [31:0]      cos_out;
    logic             bad_flips;

    int n_cmp  = 0;
    int n_fail = 0;

    result_converter_pipe #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .flips(flips), .sin_in(sin_in), .cos_in(cos_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sin_out(sin_out), .cos_out(cos_out), .bad_flips(bad_flips)
    );

    always #5 clk = ~clk;

    // Drives one sample and returns the first result seen (lat = -1 if none in 10 cycles).
    task automatic send_one(input logic [2:0] f, input logic [31:0] s, input logic [31:0] c,
                            output logic [31:0] got_sin, output logic [31:0] got_cos,
                            output logic got_bad, output int lat);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; flips = f; sin_in = s; cos_in = c;
        lat = -1; got_sin = '0; got_cos = '0; got_bad = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = k; got_sin = sin_out; got_cos = cos_out; got_bad = bad_flips;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flips = '0; sin_in = '0; cos_in = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (sin_out !== 32'h0) begin n_fail++; $display("FAIL reset_sin_out: got %h want 0", sin_out); end
        n_cmp++; if (cos_out !== 32'h0) begin n_fail++; $display("FAIL reset_cos_out: got %h want 0", cos_out); end
        n_cmp++; if (bad_flips !== 1'b0) begin n_fail++; $display("FAIL reset_bad_flips: got %b want 0", bad_flips); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] gs, gc; logic gb; int lat;
        send_one(3'b000, 32'h4000_0000, 32'h6ED9_EBA1, gs, gc, gb, lat);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", lat); end
        n_cmp++; if (gs !== 32'h3F00_0000) begin n_fail++; $display("FAIL basic_sin: got %h want 3f000000", gs); end
        n_cmp++; if (gc !== 32'h3F5D_B3D7) begin n_fail++; $display("FAIL basic_cos: got %h want 3f5db3d7", gc); end
        n_cmp++; if (gb !== 1'b0) begin n_fail++; $display("FAIL basic_bad: got %b want 0", gb); end
    endtask

    // Three quadrant codes on consecutive cycles; results on three consecutive cycles.
    task automatic test_quadrants();
        logic [2:0]  fl [3];
        logic [31:0] es [3];
        logic [31:0] ec [3];
        fl = '{3'b001, 3'b111, 3'b010};
        es = '{32'hBF5D_B3D7, 32'h3F5D_B3D7, 32'hBF00_0000};
        ec = '{32'h3F00_0000, 32'hBF00_0000, 32'hBF5D_B3D7};
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 5) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL quad_valid[%0d]: got %b want 1", k, out_valid); end
                n_cmp++; if (sin_out !== es[k-3]) begin n_fail++; $display("FAIL quad_sin[%0d]: got %h want %h", k - 3, sin_out, es[k-3]); end
                n_cmp++; if (cos_out !== ec[k-3]) begin n_fail++; $display("FAIL quad_cos[%0d]: got %h want %h", k - 3, cos_out, ec[k-3]); end
            end else begin
                n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL quad_idle[%0d]: got %b want 0", k, out_valid); end
            end
            in_valid = (k < 3);
            if (k < 3) begin flips = fl[k]; sin_in = 32'h4000_0000; cos_in = 32'h6ED9_EBA1; end
        end
    endtask

    task automatic test_edges();
        logic [2:0]  fl [6];
        logic [31:0] vs [6];
        logic [31:0] vc [6];
        logic [31:0] es [6];
        logic [31:0] ec [6];
        logic [31:0] gs, gc; logic gb; int lat;
        fl = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b110, 3'b111};
        vs = '{32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h4000_0000, 32'h8000_0000};
        vc = '{32'h6ED9_EBA1, 32'h8000_0000, 32'h6ED9_EBA1, 32'h6ED9_EBA1, 32'h6ED9_EBA1, 32'hC000_0000};
        es = '{32'hBF80_0000, 32'h3F00_0000, 32'h0000_0000, 32'h0000_0000, 32'hBF00_0000, 32'h3F00_0000};
        ec = '{32'h3F5D_B3D7, 32'h3F80_0000, 32'h3F5D_B3D7, 32'hBF5D_B3D7, 32'hBF5D_B3D7, 32'h3F80_0000};
        for (int i = 0; i < 6; i++) begin
            send_one(fl[i], vs[i], vc[i], gs, gc, gb, lat);
            n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL edge_latency[%0d]: got %0d want 3", i, lat); end
            n_cmp++; if (gs !== es[i]) begin n_fail++; $display("FAIL edge_sin[%0d]: got %h want %h", i, gs, es[i]); end
            n_cmp++; if (gc !== ec[i]) begin n_fail++; $display("FAIL edge_cos[%0d]: got %h want %h", i, gc, ec[i]); end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] vs [5];
        logic [31:0] es [5];
        logic [31:0] gs, gc; logic gb; int lat;
        vs = '{32'h7FFF_FFFF, 32'h4000_0040, 32'h4000_00C0, 32'h4000_0041, 32'h8000_0001};
`ifdef RESULT_CONVERTER_PIPE_RNE_EN
        es = '{32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0002, 32'h3F00_0001, 32'hBF80_0000};
`else
        es = '{32'h3F7F_FFFF, 32'h3F00_0000, 32'h3F00_0001, 32'h3F00_0000, 32'hBF7F_FFFF};
`endif
        for (int i = 0; i < 5; i++) begin
            send_one(3'b000, vs[i], 32'h0000_0000, gs, gc, gb, lat);
            n_cmp++; if (gs !== es[i]) begin n_fail++; $display("FAIL round_sin[%0d]: got %h want %h", i, gs, es[i]); end
            n_cmp++; if (gc !== 32'h0) begin n_fail++; $display("FAIL round_cos_zero[%0d]: got %h want 0", i, gc); end
        end
    endtask

    task automatic test_bad_flips();
        logic [2:0]  fl [3];
        logic [31:0] gs, gc; logic gb; int lat;
        fl = '{3'b100, 3'b011, 3'b101};
        for (int i = 0; i < 3; i++) begin
            send_one(fl[i], 32'h4000_0000, 32'h6ED9_EBA1, gs, gc, gb, lat);
            n_cmp++; if (gb !== 1'b1) begin n_fail++; $display("FAIL bad_flag[%0d]: got %b want 1", i, gb); end
            n_cmp++; if (gs !== 32'h3F00_0000) begin n_fail++; $display("FAIL bad_sin[%0d]: got %h want 3f000000", i, gs); end
            n_cmp++; if (gc !== 32'h3F5D_B3D7) begin n_fail++; $display("FAIL bad_cos[%0d]: got %h want 3f5db3d7", i, gc); end
        end
        send_one(3'b001, 32'h4000_0000, 32'h6ED9_EBA1, gs, gc, gb, lat);
        n_cmp++; if (gb !== 1'b0) begin n_fail++; $display("FAIL bad_clears: got %b want 0", gb); end
    endtask

    // Five samples against a stalled consumer, then release and drain in order.
    task automatic test_backpressure();
        logic [31:0] vs [5];
        logic [31:0] es [5];
        int idx = 0;
        int oidx = 0;
        int cyc = 0;
        vs = '{32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h6000_0000, 32'h0800_0000};
        es = '{32'h3F00_0000, 32'h3E80_0000, 32'h3E00_0000, 32'h3F40_0000, 32'h3D80_0000};
        flips = 3'b000; cos_in = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = (idx < 5);
            sin_in = (idx < 5) ? vs[idx] : 32'h0;
            #1;
            if (k >= 3) begin
                n_cmp++; if (out_valid !== 1'b1 || sin_out !== es[0]) begin n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b sin=%h want valid=1 sin=%h", k, out_valid, sin_out, es[0]); end
            end
            if (in_valid && in_ready) idx++;
        end
        n_cmp++; if (idx !== 3) begin n_fail++; $display("FAIL bp_accepted: got %0d want 3", idx); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        while (oidx < 5 && cyc < 30) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (idx < 5);
            sin_in = (idx < 5) ? vs[idx] : 32'h0;
            #1;
            if (out_valid) begin
                n_cmp++; if (sin_out !== es[oidx]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", oidx, sin_out, es[oidx]); end
                oidx++;
            end
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        n_cmp++; if (oidx !== 5) begin n_fail++; $display("FAIL bp_drained: got %0d results want 5", oidx); end
        in_valid = 1'b0;
        oidx = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) oidx++;
        end
        n_cmp++; if (oidx !== 0) begin n_fail++; $display("FAIL bp_no_duplicates: got %0d extra results want 0", oidx); end
    endtask

    task automatic test_reset_mid_stream();
        logic [31:0] gs, gc; logic gb; int lat;
        int seen = 0;
        out_ready = 1'b1; flips = 3'b000; sin_in = 32'h4000_0000; cos_in = 32'h6ED9_EBA1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
        end
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        #1; rst = 1'b1; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (sin_out !== 32'h0) begin n_fail++; $display("FAIL mid_reset_sin: got %h want 0", sin_out); end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL mid_flushed: got %0d stale results want 0", seen); end
        send_one(3'b000, 32'h2000_0000, 32'h6ED9_EBA1, gs, gc, gb, lat);
        n_cmp++; if (lat !== 3 || gs !== 32'h3E80_0000) begin n_fail++; $display("FAIL mid_recover: got lat=%0d sin=%h want lat=3 sin=3e800000", lat, gs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_quadrants();
        test_edges();
        test_rounding();
        test_bad_flips();
        test_backpressure();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
